// File: rtl/mc_adder_pkg.sv
// Shared types and helpers for the multicycle adder controller.
// Optional feature macro: MC_ADDER_CIN_EN (adds a carry-in operand port).
package mc_adder_pkg;

    // Controller states; explicit encoding keeps the state register two bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Width of the slice index: clog2 of the slice count, never below one bit.
    function automatic int idx_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the ripple slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/slice_adder.sv
// SLICE_WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
module slice_adder #(
    parameter int SLICE_WIDTH = 8
) (
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [SLICE_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [SLICE_WIDTH:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[SLICE_WIDTH];

    for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

endmodule

// File: rtl/multicycle_adder_ctrl.sv
// Wide adder that reuses one SLICE_WIDTH-bit slice adder over NSLICE cycles,
// registering the carry between slices. Operands and result use valid/ready.
// Optional feature macro: MC_ADDER_CIN_EN adds a carry-in port sampled at accept.
module multicycle_adder_ctrl
    import mc_adder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
`ifdef MC_ADDER_CIN_EN
    input  logic                  cin,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   sum,
    output logic                  busy
);

    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W  = idx_width(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    mc_state_t             state;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  carry_q;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH:0]   sum_q;

    logic                  carry_init;
    int                    base;
    logic [SLICE_WIDTH-1:0] slice_sum;
    logic                   slice_cout;

`ifdef MC_ADDER_CIN_EN
    assign carry_init = cin;
`else
    assign carry_init = 1'b0;
`endif

    // Bit offset of the slice being worked on this cycle.
    assign base = int'(idx) * SLICE_WIDTH;

    slice_adder #(
        .SLICE_WIDTH(SLICE_WIDTH)
    ) u_slice (
        .a   (a_q[base +: SLICE_WIDTH]),
        .b   (b_q[base +: SLICE_WIDTH]),
        .cin (carry_q),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    // Handshake and status flags come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;

    // Sequencer: accept operands, walk the slices low to high, hold the result.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_init;
                        idx     <= '0;
                        sum_q   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_q[base +: SLICE_WIDTH] <= slice_sum;
                    carry_q                    <= slice_cout;
                    if (idx == LAST_IDX) begin
                        sum_q[DATA_WIDTH] <= slice_cout;
                        idx               <= '0;
                        state             <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Self-checking bench for multicycle_adder_ctrl: directed cases plus randomized
// transactions compared against a plain-arithmetic reference (a + b + cin).
module tb_multicycle_adder_ctrl;

    localparam int DATA_WIDTH  = 32;
    localparam int SLICE_WIDTH = 8;
    localparam int NSLICE      = DATA_WIDTH / SLICE_WIDTH;

    logic                  clk;
    logic                  resetn;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH:0]   sum;
    logic                  busy;
`ifdef MC_ADDER_CIN_EN
    logic                  cin;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multicycle_adder_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLICE_WIDTH(SLICE_WIDTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef MC_ADDER_CIN_EN
        .cin      (cin),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full-precision sum of the operands.
    function automatic logic [DATA_WIDTH:0] ref_sum(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] y,
                                                    input logic ci);
        return {1'b0, x} + {1'b0, y} + {{DATA_WIDTH{1'b0}}, ci};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".busy"},      64'(busy),      64'd0);
        check({tag, ".sum"},       64'(sum),       64'd0);
        check({tag, ".in_ready"},  64'(in_ready),  64'd1);
    endtask

    // One full transaction: offer operands, measure latency, stall the result
    // for `stall` cycles while presenting junk operands, then hand it off.
    task automatic do_add(input string tag, input logic [DATA_WIDTH-1:0] x,
                          input logic [DATA_WIDTH-1:0] y, input logic ci, input int stall);
        logic [DATA_WIDTH:0] exp_sum;
        int                  cyc;
        bit                  seen;
`ifdef MC_ADDER_CIN_EN
        exp_sum = ref_sum(x, y, ci);
`else
        exp_sum = ref_sum(x, y, 1'b0);
`endif
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) begin
            check({tag, ".ready_timeout"}, 64'd0, 64'd1);
            return;
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
`ifdef MC_ADDER_CIN_EN
        cin      = ci;
`endif
        tick();  // accept edge T0
        check({tag, ".busy_after_accept"}, 64'(busy), 64'd1);
        // Operands offered while busy must be ignored.
        seen = 0;
        cyc  = 0;
        for (int i = 1; i <= 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            if (out_valid) begin
                seen = 1;
                break;
            end
            tick();
            cyc = i;
        end
        if (!seen) begin
            check({tag, ".done_timeout"}, 64'd0, 64'd1);
            return;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(NSLICE));
        check({tag, ".sum"}, 64'(sum), 64'(exp_sum));
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            tick();
            check({tag, ".stall_sum"},       64'(sum),       64'(exp_sum));
            check({tag, ".stall_in_ready"},  64'(in_ready),  64'd0);
            check({tag, ".stall_busy"},      64'(busy),      64'd1);
            check({tag, ".stall_out_valid"}, 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();  // result handshake edge Td
        out_ready = 1'b0;
        check({tag, ".post_in_ready"},  64'(in_ready),  64'd1);
        check({tag, ".post_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef MC_ADDER_CIN_EN
        cin       = 1'b0;
`endif
        #1;
        check_reset_values("reset_async");
        repeat (3) tick();
        check_reset_values("reset_held");
        resetn = 1'b1;
        tick();
        check_reset_values("reset_release");

        do_add("basic",  32'h0000_0001, 32'h0000_0002, 1'b0, 0);
        check("basic.value", 64'(ref_sum(32'h1, 32'h2, 1'b0)), 64'h0_0000_0003);
        do_add("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        do_add("stall",  32'h1234_5678, 32'h1111_1111, 1'b0, 5);
        do_add("after_stall", 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 0);

        // Reset mid-RUN: accept at T0, pulse reset just after edge T0+2.
        in_valid = 1'b1;
        a        = 32'h0101_0101;
        b        = 32'h0101_0101;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check_reset_values("mid_reset");
        tick();
        resetn = 1'b1;
        tick();
        check_reset_values("mid_reset_release");
        do_add("after_reset", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);

`ifdef MC_ADDER_CIN_EN
        do_add("cin1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        do_add("cin0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            do_add("rand", $urandom, $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
